// File: rtl/riscv_pkg.sv
// Shared decode definitions for the ID stage: opcodes, ALU/branch codes,
// immediate formats, control bundle and the immediate generator.
package riscv_pkg;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;
    localparam int REG_AW   = $clog2(NUM_REGS);

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        ALU_R     = 3'b000,
        ALU_I     = 3'b001,
        ALU_MEM   = 3'b010,
        ALU_BR    = 3'b011,
        ALU_JUMP  = 3'b100,
        ALU_LUI   = 3'b101,
        ALU_AUIPC = 3'b110
    } alu_op_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_COND = 2'b01,
        BR_JAL  = 2'b10,
        BR_JALR = 2'b11
    } branch_type_e;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_type_e;

    typedef struct packed {
        logic         reg_write;
        logic         mem_read;
        logic         mem_write;
        logic         mem_to_reg;
        logic         alu_src;
        alu_op_e      alu_op;
        branch_type_e branch_type;
    } ctrl_t;

    // Sign-extended immediate for the given instruction format.
    function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] instr,
                                                input imm_type_e kind);
        logic [XLEN-1:0] imm;
        imm = '0;
        case (kind)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// IF/ID, write-back and ID/EX signals of the decode stage.
// slave: the decode stage itself; master: the surrounding pipeline.
interface id_stage_if;
    import riscv_pkg::*;

    logic [XLEN-1:0]   IF_pc_out;
    logic [31:0]       IF_instr_out;
    logic              ex_flush;
    logic              WB_RegWrite;
    logic [REG_AW-1:0] WB_rd;
    logic [XLEN-1:0]   WB_data;

    logic              PC_write;
    logic              IFID_RegWrite;
    logic [XLEN-1:0]   ID_pc;
    logic [XLEN-1:0]   ID_imm;
    logic [XLEN-1:0]   ID_rs1_data;
    logic [XLEN-1:0]   ID_rs2_data;
    logic [REG_AW-1:0] ID_rs1;
    logic [REG_AW-1:0] ID_rs2;
    logic [REG_AW-1:0] ID_rd;
    logic [2:0]        ID_funct3;
    logic [6:0]        ID_funct7;
    logic              ID_RegWrite;
    logic              ID_MemRead;
    logic              ID_MemWrite;
    logic              ID_MemtoReg;
    logic              ID_ALUSrc;
    logic [2:0]        ID_ALUOp;
    logic [1:0]        ID_BranchType;

    modport slave (
        input  IF_pc_out, IF_instr_out, ex_flush, WB_RegWrite, WB_rd, WB_data,
        output PC_write, IFID_RegWrite, ID_pc, ID_imm, ID_rs1_data, ID_rs2_data,
               ID_rs1, ID_rs2, ID_rd, ID_funct3, ID_funct7, ID_RegWrite,
               ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_ALUOp,
               ID_BranchType
    );

    modport master (
        output IF_pc_out, IF_instr_out, ex_flush, WB_RegWrite, WB_rd, WB_data,
        input  PC_write, IFID_RegWrite, ID_pc, ID_imm, ID_rs1_data, ID_rs2_data,
               ID_rs1, ID_rs2, ID_rd, ID_funct3, ID_funct7, ID_RegWrite,
               ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_ALUOp,
               ID_BranchType
    );

endinterface

// File: rtl/id_stage_regfile.sv
// Integer register file: NUM_REGS x XLEN, two combinational read ports,
// one write port, x0 hardwired to zero.
// Optional macro REGFILE_BYPASS_EN: a same-cycle write is visible on the
// read ports (write-through); otherwise reads return the stored value.
module regfile
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [XLEN-1:0]   rdata1,
    output logic [XLEN-1:0]   rdata2
);

    logic [XLEN-1:0] regs [1:NUM_REGS-1];
    logic            wr_en;

    assign wr_en = we && (waddr != '0);

    // Storage for x1..x31; cleared by reset, written from write-back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[waddr] <= wdata;
        end
    end

    // Read ports; x0 reads as zero.
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (raddr1 != '0) rdata1 = regs[raddr1];
        if (raddr2 != '0) rdata2 = regs[raddr2];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (waddr == raddr1)) rdata1 = wdata;
        if (wr_en && (waddr == raddr2)) rdata2 = wdata;
`endif
    end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: control decoder, immediate generator,
// register file, load-use hazard detection and the ID/EX register.
// Optional macro REGFILE_BYPASS_EN enables write-through in the register file.
module id_stage
    import riscv_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    id_stage_if.slave bus
);

    logic [31:0]       instr;
    logic [6:0]        opcode;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;

    ctrl_t             ctrl;
    imm_type_e         imm_type;
    logic              valid;
    logic              use_rs1;
    logic              use_rs2;
    logic              hz;
    logic              stall;
    logic              bubble;

    ctrl_t             ctrl_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   imm_q;
    logic [XLEN-1:0]   rs1_data_q;
    logic [XLEN-1:0]   rs2_data_q;
    logic [REG_AW-1:0] rs1_q;
    logic [REG_AW-1:0] rs2_q;
    logic [REG_AW-1:0] rd_q;
    logic [2:0]        funct3_q;
    logic [6:0]        funct7_q;

    assign instr    = bus.IF_instr_out;
    assign opcode   = instr[6:0];
    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];

    regfile u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (bus.WB_RegWrite),
        .waddr  (bus.WB_rd),
        .wdata  (bus.WB_data),
        .raddr1 (rs1_addr),
        .raddr2 (rs2_addr),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

    // Main control decoder: control bundle, immediate format, operand usage.
    always_comb begin
        ctrl     = '0;
        imm_type = IMM_NONE;
        valid    = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        case (opcode)
            OPC_R: begin
                valid = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_R;
            end
            OPC_I_ALU: begin
                valid = 1'b1; use_rs1 = 1'b1; imm_type = IMM_I;
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_I;
            end
            OPC_LOAD: begin
                valid = 1'b1; use_rs1 = 1'b1; imm_type = IMM_I;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.alu_op     = ALU_MEM;
            end
            OPC_STORE: begin
                valid = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; imm_type = IMM_S;
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_MEM;
            end
            OPC_BRANCH: begin
                valid = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; imm_type = IMM_B;
                ctrl.branch_type = BR_COND;
                ctrl.alu_op      = ALU_BR;
            end
            OPC_JAL: begin
                valid = 1'b1; imm_type = IMM_J;
                ctrl.reg_write   = 1'b1;
                ctrl.branch_type = BR_JAL;
                ctrl.alu_op      = ALU_JUMP;
            end
            OPC_JALR: begin
                valid = 1'b1; use_rs1 = 1'b1; imm_type = IMM_I;
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src     = 1'b1;
                ctrl.branch_type = BR_JALR;
                ctrl.alu_op      = ALU_JUMP;
            end
            OPC_LUI: begin
                valid = 1'b1; imm_type = IMM_U;
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_LUI;
            end
            OPC_AUIPC: begin
                valid = 1'b1; imm_type = IMM_U;
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_AUIPC;
            end
            default: ;
        endcase
    end

    assign imm = gen_imm(instr, imm_type);

    // Load-use hazard against the load currently in ID/EX; flush wins.
    always_comb begin
        hz = ctrl_q.mem_read && (rd_q != '0) &&
             ((use_rs1 && (rd_q == rs1_addr)) || (use_rs2 && (rd_q == rs2_addr)));
        stall  = hz && !bus.ex_flush;
        bubble = bus.ex_flush || hz || !valid;
    end

    assign bus.PC_write      = !stall;
    assign bus.IFID_RegWrite = !stall;

    // ID/EX pipeline register; bubbles clear every field, not just controls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q     <= '0;
            pc_q       <= '0;
            imm_q      <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            funct3_q   <= '0;
            funct7_q   <= '0;
        end else if (bubble) begin
            ctrl_q     <= '0;
            pc_q       <= '0;
            imm_q      <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            funct3_q   <= '0;
            funct7_q   <= '0;
        end else begin
            ctrl_q     <= ctrl;
            pc_q       <= bus.IF_pc_out;
            imm_q      <= imm;
            rs1_data_q <= rs1_data;
            rs2_data_q <= rs2_data;
            rs1_q      <= rs1_addr;
            rs2_q      <= rs2_addr;
            rd_q       <= instr[11:7];
            funct3_q   <= instr[14:12];
            funct7_q   <= instr[31:25];
        end
    end

    assign bus.ID_pc         = pc_q;
    assign bus.ID_imm        = imm_q;
    assign bus.ID_rs1_data   = rs1_data_q;
    assign bus.ID_rs2_data   = rs2_data_q;
    assign bus.ID_rs1        = rs1_q;
    assign bus.ID_rs2        = rs2_q;
    assign bus.ID_rd         = rd_q;
    assign bus.ID_funct3     = funct3_q;
    assign bus.ID_funct7     = funct7_q;
    assign bus.ID_RegWrite   = ctrl_q.reg_write;
    assign bus.ID_MemRead    = ctrl_q.mem_read;
    assign bus.ID_MemWrite   = ctrl_q.mem_write;
    assign bus.ID_MemtoReg   = ctrl_q.mem_to_reg;
    assign bus.ID_ALUSrc     = ctrl_q.alu_src;
    assign bus.ID_ALUOp      = ctrl_q.alu_op;
    assign bus.ID_BranchType = ctrl_q.branch_type;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus randomized
// instruction streams against a behavioural pipeline model.
// Honours REGFILE_BYPASS_EN in the model when the build defines it.
module tb_id_stage;

    logic clk;
    logic rst;

    id_stage_if bus ();

    id_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Model state: architectural registers and the expected ID/EX contents.
    logic [31:0] regs_m [32];
    logic [31:0] e_pc, e_imm, e_d1, e_d2;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic [2:0]  e_f3;
    logic [6:0]  e_f7;
    logic [9:0]  e_ctrl;   // {RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,ALUOp,BranchType}
    logic        obs_pcw;
    logic        obs_ifid;
    logic        last_stall;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] dut_ctrl();
        return {bus.ID_RegWrite, bus.ID_MemRead, bus.ID_MemWrite, bus.ID_MemtoReg,
                bus.ID_ALUSrc, bus.ID_ALUOp, bus.ID_BranchType};
    endfunction

    task automatic model_clear_idex();
        e_pc = 0; e_imm = 0; e_d1 = 0; e_d2 = 0;
        e_rs1 = 0; e_rs2 = 0; e_rd = 0; e_f3 = 0; e_f7 = 0; e_ctrl = 0;
    endtask

    task automatic compare_outputs();
        check("ctrl",     {22'd0, dut_ctrl()},       {22'd0, e_ctrl});
        check("pc",       bus.ID_pc,                 e_pc);
        check("imm",      bus.ID_imm,                e_imm);
        check("rs1_data", bus.ID_rs1_data,           e_d1);
        check("rs2_data", bus.ID_rs2_data,           e_d2);
        check("fields",   {5'd0, bus.ID_rs1, bus.ID_rs2, bus.ID_rd, bus.ID_funct3, bus.ID_funct7},
                          {5'd0, e_rs1, e_rs2, e_rd, e_f3, e_f7});
    endtask

    // Reference decode from the opcode table, immediates via integer arithmetic.
    function automatic void ref_decode(input logic [31:0] i, output logic ok,
                                       output logic [9:0] c, output logic [31:0] imm,
                                       output logic u1, output logic u2);
        int s;
        int v_i, v_s, v_b, v_j;
        s   = $signed(i);
        v_i = s >>> 20;
        v_s = (s >>> 25) * 32 + int'(i[11:7]);
        v_b = (s >>> 31) * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
        v_j = (s >>> 31) * 1048576 + int'(i[19:12]) * 4096 + int'(i[20]) * 2048
              + int'(i[30:21]) * 2;
        ok = 1'b1; u1 = 1'b1; u2 = 1'b0; imm = 0; c = 0;
        case (i[6:0])
            7'h33: begin c = {5'b10000, 3'd0, 2'd0}; u2 = 1'b1; end
            7'h13: begin c = {5'b10001, 3'd1, 2'd0}; imm = v_i; end
            7'h03: begin c = {5'b11011, 3'd2, 2'd0}; imm = v_i; end
            7'h23: begin c = {5'b00101, 3'd2, 2'd0}; imm = v_s; u2 = 1'b1; end
            7'h63: begin c = {5'b00000, 3'd3, 2'd1}; imm = v_b; u2 = 1'b1; end
            7'h6F: begin c = {5'b10000, 3'd4, 2'd2}; imm = v_j; u1 = 1'b0; end
            7'h67: begin c = {5'b10001, 3'd4, 2'd3}; imm = v_i; end
            7'h37: begin c = {5'b10001, 3'd5, 2'd0}; imm = i & 32'hFFFFF000; u1 = 1'b0; end
            7'h17: begin c = {5'b10001, 3'd6, 2'd0}; imm = i & 32'hFFFFF000; u1 = 1'b0; end
            default: begin ok = 1'b0; u1 = 1'b0; end
        endcase
    endfunction

    function automatic logic [31:0] read_m(input logic [4:0] a, input logic we,
                                           input logic [4:0] wrd, input logic [31:0] wd);
        if (a == 0) return 0;
`ifdef REGFILE_BYPASS_EN
        if (we && wrd == a) return wd;
`endif
        return regs_m[a];
    endfunction

    // One pipeline cycle: drive at negedge, check stall controls, then ID/EX after posedge.
    task automatic step(input logic [31:0] instr, input logic [31:0] pc, input logic flush,
                        input logic we, input logic [4:0] wrd, input logic [31:0] wd);
        logic ok, u1, u2, hz, stalled;
        logic [9:0] c;
        logic [31:0] imm;
        @(negedge clk);
        bus.IF_instr_out = instr;
        bus.IF_pc_out    = pc;
        bus.ex_flush     = flush;
        bus.WB_RegWrite  = we;
        bus.WB_rd        = wrd;
        bus.WB_data      = wd;
        #1;
        ref_decode(instr, ok, c, imm, u1, u2);
        hz = e_ctrl[8] && (e_rd != 0) &&
             ((u1 && e_rd == instr[19:15]) || (u2 && e_rd == instr[24:20]));
        stalled = hz && !flush;
        obs_pcw  = bus.PC_write;
        obs_ifid = bus.IFID_RegWrite;
        check("pc_write",   {31'd0, obs_pcw},  {31'd0, !stalled});
        check("ifid_write", {31'd0, obs_ifid}, {31'd0, !stalled});
        if (flush || hz || !ok) begin
            model_clear_idex();
        end else begin
            e_ctrl = c; e_pc = pc; e_imm = imm;
            e_d1 = read_m(instr[19:15], we, wrd, wd);
            e_d2 = read_m(instr[24:20], we, wrd, wd);
            e_rs1 = instr[19:15]; e_rs2 = instr[24:20]; e_rd = instr[11:7];
            e_f3 = instr[14:12]; e_f7 = instr[31:25];
        end
        if (we && wrd != 0) regs_m[wrd] = wd;
        @(posedge clk);
        #1;
        compare_outputs();
        last_stall = stalled;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int k;
        r = $urandom;
        r[11:7]  = 5'($urandom_range(0, 7));
        r[19:15] = 5'($urandom_range(0, 7));
        r[24:20] = 5'($urandom_range(0, 7));
        k = $urandom_range(0, 13);
        case (k)
            0, 1, 2: r[6:0] = 7'h03;
            3, 4:    r[6:0] = 7'h33;
            5:       r[6:0] = 7'h13;
            6:       r[6:0] = 7'h23;
            7:       r[6:0] = 7'h63;
            8:       r[6:0] = 7'h6F;
            9:       r[6:0] = 7'h67;
            10:      r[6:0] = 7'h37;
            11:      r[6:0] = 7'h17;
            12:      r = 0;
            default: r[6:0] = 7'h7F;
        endcase
        return r;
    endfunction

    task automatic idle_inputs();
        bus.IF_instr_out = 0; bus.IF_pc_out = 0; bus.ex_flush = 0;
        bus.WB_RegWrite = 0; bus.WB_rd = 0; bus.WB_data = 0;
    endtask

    initial begin
        logic [31:0] cur_i, cur_pc;
        logic fl, after_flush, we;
        logic [4:0] wrd;
        logic [31:0] wd;

        n_vec = 0; n_err = 0; last_stall = 0;
        for (int i = 0; i < 32; i++) regs_m[i] = 0;
        model_clear_idex();
        idle_inputs();
        rst = 1'b0;
        #2;
        compare_outputs();
        check("rst_pc_write", {31'd0, bus.PC_write}, 32'd1);
        @(negedge clk);
        rst = 1'b1;

        // ADDI x1,x0,-1 at PC 0x10
        step(32'hFFF00093, 32'h10, 0, 0, 0, 0);
        check("addi_imm", bus.ID_imm, 32'hFFFFFFFF);
        check("addi_rd", {27'd0, bus.ID_rd}, 32'd1);
        check("addi_ctrl", {22'd0, dut_ctrl()}, {22'd0, 5'b10001, 3'b001, 2'b00});
        check("addi_pc", bus.ID_pc, 32'h10);

        // Register file write, then read back through add x4,x3,x0
        step(0, 32'h14, 0, 1, 5'd3, 32'hDEADBEEF);
        step(32'h00018233, 32'h18, 0, 0, 0, 0);
        check("rf_x3", bus.ID_rs1_data, 32'hDEADBEEF);
        step(0, 32'h1C, 0, 1, 5'd0, 32'h1234);
        step(32'h00000233, 32'h20, 0, 0, 0, 0);
        check("rf_x0", bus.ID_rs1_data, 32'h0);

        // Load-use: lw x2,0(x1) then add x3,x2,x2
        step(32'h0000A103, 32'h24, 0, 0, 0, 0);
        step(32'h002101B3, 32'h28, 0, 0, 0, 0);
        check("lu_pcw",  {31'd0, obs_pcw},  32'd0);
        check("lu_ifid", {31'd0, obs_ifid}, 32'd0);
        check("lu_bubble", {22'd0, dut_ctrl()}, 32'd0);
        step(32'h002101B3, 32'h28, 0, 0, 0, 0);
        check("lu_resume", {31'd0, bus.ID_RegWrite}, 32'd1);

        // Flush with a pending load-use hazard, then a zero instruction
        step(32'h0000A103, 32'h2C, 0, 0, 0, 0);
        step(32'h002101B3, 32'h30, 1, 0, 0, 0);
        check("fl_pcw",  {31'd0, obs_pcw},  32'd1);
        check("fl_ifid", {31'd0, obs_ifid}, 32'd1);
        check("fl_bubble", {22'd0, dut_ctrl()}, 32'd0);
        step(0, 32'h34, 0, 0, 0, 0);
        check("zero_bubble", {22'd0, dut_ctrl()}, 32'd0);

        // Same-cycle write and read of x7 via addi x8,x7,0
        step(0, 32'h38, 0, 1, 5'd7, 32'h11);
        step(32'h00038413, 32'h3C, 0, 1, 5'd7, 32'h55);
`ifdef REGFILE_BYPASS_EN
        check("bypass_x7", bus.ID_rs1_data, 32'h55);
`else
        check("nobypass_x7", bus.ID_rs1_data, 32'h11);
`endif

        // Mid-run asynchronous reset with live ID/EX and register contents
        step(0, 32'h40, 0, 1, 5'd5, 32'hABCD);
        step(32'h0000A103, 32'h44, 0, 0, 0, 0);
        @(negedge clk);
        #2;
        idle_inputs();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) regs_m[i] = 0;
        model_clear_idex();
        compare_outputs();
        check("mid_rst_pcw", {31'd0, bus.PC_write}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        step(32'h00028333, 32'h48, 0, 0, 0, 0);
        check("rst_x5", bus.ID_rs1_data, 32'h0);
        check("rst_pcw", {31'd0, obs_pcw}, 32'd1);

        // Randomized instruction stream with a simple fetch model
        cur_i = 0; cur_pc = 32'h100; after_flush = 0; last_stall = 0;
        for (int n = 0; n < 600; n++) begin
            if (!last_stall) begin
                cur_i  = after_flush ? 32'h0 : rand_instr();
                cur_pc = cur_pc + 4;
            end
            fl  = ($urandom_range(0, 9) == 0);
            we  = 1'($urandom_range(0, 1));
            wrd = 5'($urandom_range(0, 7));
            wd  = $urandom;
            step(cur_i, cur_pc, fl, we, wrd, wd);
            after_flush = fl;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage directly downstream of the fetch stage. Consumes the IF/ID pipeline register: fetched PC and instruction, where the instruction word is 0 after a flush.
- Contains the 32-entry integer register file, immediate generator, main control decoder, load-use hazard detector and the ID/EX pipeline register.
- Drives the stall controls PC_write and IFID_RegWrite back to the fetch stage.

Parameters:
- XLEN, 32, datapath and register width.
- NUM_REGS, 32, register-file entries; x0 is hardwired to 0.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- IF_pc_out  in  32  PC of the instruction held in IF/ID.
- IF_instr_out  in  32  instruction held in IF/ID; 0 = bubble.
- ex_flush  in  1  taken branch/jump resolved in EX; squash the instruction currently in ID.
- WB_RegWrite  in  1  write-back enable.
- WB_rd  in  5  write-back destination.
- WB_data  in  32  write-back data.
- PC_write  out  1  to fetch; 0 holds PC.
- IFID_RegWrite  out  1  to fetch; 0 holds IF/ID.
- ID_pc, ID_imm, ID_rs1_data, ID_rs2_data  out  32 each  ID/EX register.
- ID_rs1, ID_rs2, ID_rd  out  5 each  ID/EX register.
- ID_funct3  out  3;  ID_funct7  out  7.
- ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc  out  1 each.
- ID_ALUOp  out  3;  ID_BranchType  out  2 (00 none, 01 cond branch, 10 JAL, 11 JALR).

Behaviour:
- Reset (rst=0, asynchronous):
  - All ID/EX outputs are 0.
  - All registers x1..x31 are 0.
  - PC_write and IFID_RegWrite are combinational and follow the hazard rule, so they read 1 during reset.
- Register file:
  - Write on rising edge when WB_RegWrite=1 and WB_rd!=0.
  - Writes to x0 are ignored; reads of x0 return 0.
  - Two combinational read ports, addressed by instr[19:15] and instr[24:20].
- Decode by opcode (instr[6:0]):
  - R 0110011: RegWrite=1, ALUOp=000.
  - I-ALU 0010011: RegWrite=1, ALUSrc=1, ALUOp=001, I-imm.
  - LOAD 0000011: RegWrite=1, MemRead=1, MemtoReg=1, ALUSrc=1, ALUOp=010, I-imm.
  - STORE 0100011: MemWrite=1, ALUSrc=1, ALUOp=010, S-imm.
  - BRANCH 1100011: BranchType=01, ALUOp=011, B-imm.
  - JAL 1101111: RegWrite=1, BranchType=10, ALUOp=100, J-imm.
  - JALR 1100111: RegWrite=1, ALUSrc=1, BranchType=11, ALUOp=100, I-imm.
  - LUI 0110111: RegWrite=1, ALUSrc=1, ALUOp=101, U-imm.
  - AUIPC 0010111: RegWrite=1, ALUSrc=1, ALUOp=110, U-imm.
  - Any other opcode, including 0: bubble (all controls 0, imm=0).
- Immediates: sign-extended from instr[31]. B-imm and J-imm have bit0=0. U-imm has its low 12 bits = 0.
- Register-use flags: rs1 is used by all formats except LUI, AUIPC and JAL. rs2 is used by R, STORE and BRANCH only.
- Load-use hazard: hz = ID_MemRead & (ID_rd!=0) & ((use_rs1 & ID_rd==rs1) | (use_rs2 & ID_rd==rs2)), evaluated against the registered ID/EX outputs.
- Stall: when hz=1 and ex_flush=0, PC_write=0 and IFID_RegWrite=0 for exactly one cycle, and a bubble is latched into ID/EX. On the next cycle ID_MemRead=0, so the stall clears.
- Flush: when ex_flush=1, a bubble is latched into ID/EX and PC_write=IFID_RegWrite=1. The fetch stage performs its own instruction flush. ex_flush has priority over hz.
- Bubble definition: all control outputs 0. Data and address fields may carry don't-care values, but the implementation zeroes them.
- Latency: one cycle from IF/ID to ID/EX.
- Simultaneous WB write and ID read of the same register: the read returns the old value unless REGFILE_BYPASS_EN is defined.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when WB_RegWrite=1, WB_rd!=0 and WB_rd equals a read address, that read port returns WB_data in the same cycle (write-through).
- Undefined: read ports return the stored value. The downstream forwarding unit must then cover the WB-to-ID case.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants;
  - ALUOp codes (000..110);
  - BranchType codes;
  - an imm-type enum (I, S, B, U, J, NONE);
  - a packed struct for the control bundle.
- Natural sub-module: regfile (32x32, 2 read ports, 1 write port, asynchronous active-low reset, bypass under the macro). Decoder, hazard logic and ID/EX register stay in id_stage.

Test Plan:
- Reset: rst=0 mid-run → all ID_* outputs 0 immediately; after release, reading x5 gives 0 and PC_write=1.
- ADDI decode: IF_instr_out=0xFFF00093 (addi x1,x0,-1), IF_pc_out=0x10 → next edge: ID_imm=0xFFFFFFFF, ID_rd=1, ALUSrc=1, ALUOp=001, RegWrite=1, ID_pc=0x10.
- Register file: write x3=0xDEADBEEF via WB, then decode add x4,x3,x0 → ID_rs1_data=0xDEADBEEF. A write to x0 with 0x1234 → x0 reads 0.
- Load-use: lw x2,0(x1) followed by add x3,x2,x2 → one cycle with PC_write=0, IFID_RegWrite=0, ID/EX controls all 0; next cycle the add is latched with RegWrite=1.
- Flush priority: hz condition and ex_flush=1 together → ID/EX bubble, PC_write=1, IFID_RegWrite=1. Instruction 0 → bubble.
- Bypass (macro on): WB x7=0x55 on the same cycle as decoding an instruction reading x7 → ID_rs1_data=0x55. With the macro off → the old value.
